// File: rtl/csa_accum_if.sv
// rtl/csa_accum_if.sv - operand/result handshake bundle for csa_accum
interface csa_accum_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/csa_accum.sv
// rtl/csa_accum.sv - carry-save multi-operand accumulator
// One 3:2 compressor row per accepted operand, then iterative carry resolve to binary.
module csa_accum #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  csa_accum_if.slave  bus
);
  if (ACC_WIDTH < WIDTH) begin : g_width_check
    $error("csa_accum: ACC_WIDTH must be >= WIDTH");
  end

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic [ACC_WIDTH-1:0] x;
  logic                 live_q;

  assign x = ACC_WIDTH'(bus.in_data);

  // live_q keeps in_ready low while rst is held, since ACCUM is also the reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid && live_q) begin
          s_d = s_q ^ c_q ^ x;
          c_d = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
          if (bus.in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (c_q == '0) begin
          state_d = OUTPUT;
        end else begin
          s_d = s_q ^ c_q;
          c_d = (s_q & c_q) << 1;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          s_d     = '0;
          c_d     = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        s_d     = '0;
        c_d     = '0;
      end
    endcase
  end

  assign bus.in_ready  = live_q && (state_q == ACCUM);
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_data  = (state_q == OUTPUT) ? s_q : '0;
  assign bus.busy      = (state_q == RESOLVE) || (state_q == OUTPUT);
endmodule

// File: doc/csa_accum.md
# csa_accum

Sequential multi-operand unsigned accumulator. Each accepted operand is folded into a redundant sum/carry register pair through one 3:2 compressor row per cycle. A bounded iterative carry-resolve phase then produces the binary total. The block sits directly upstream of the full/half-adder cell mapping: its compressor row synthesises to `$fa` cells, and zero-carry bit positions collapse to half adders. It serves as the flow's reference design for exercising adder-cell mapping on the sky130 OSU 12T library.

## Interface
Parameters:
- `WIDTH`, 16: operand width.
- `ACC_WIDTH`, 24: accumulator/result width. Must satisfy `ACC_WIDTH >= WIDTH`; an elaboration error is raised otherwise.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operand present.
- `in_ready`, output, 1: block accepts an operand this cycle.
- `in_data`, input, `WIDTH`: unsigned operand, zero-extended to `ACC_WIDTH`.
- `in_last`, input, 1: final operand of the current group; qualified by the input handshake.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `out_data`, output, `ACC_WIDTH`: group sum, modulo 2^`ACC_WIDTH`.
- `busy`, output, 1: high in RESOLVE or OUTPUT.

## Operation
- Internal registers:
  - `S[ACC_WIDTH]`: sum vector.
  - `C[ACC_WIDTH]`: carry vector.
  - `state`: one of ACCUM, RESOLVE, OUTPUT.
- Invariant: the true running total mod 2^`ACC_WIDTH` equals `S + C` at all times.
- Reset (asynchronous, effective immediately):
  - `S`, `C` = 0; `state` = ACCUM.
  - `out_valid` = 0, `out_data` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high; it is 1 from the first cycle after deassertion.
- ACCUM:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, with `X` = zero-extended `in_data`:
    - `S <= S ^ C ^ X`.
    - `C <= ((S&C)|(S&X)|(C&X)) << 1`, truncated to `ACC_WIDTH`; the bit shifted out of the MSB is discarded (modulo wrap).
  - If `in_last` is set on that beat: next state is RESOLVE.
  - With no handshake, registers hold.
- RESOLVE (`in_ready` = 0):
  - If `C == 0`: next state is OUTPUT; `S` and `C` are unchanged.
  - Otherwise: `S <= S ^ C` and `C <= (S & C) << 1`, truncated.
  - `C` reaches zero in at most `ACC_WIDTH` iterations.
- OUTPUT:
  - `out_valid` = 1 and `out_data` = `S`.
  - Both are held stable until `out_ready` is sampled high.
  - On the handshake: `S`, `C` <= 0 and next state is ACCUM.
- `out_data` reads 0 whenever `out_valid` = 0.
- `in_data` and `in_last` are ignored when there is no input handshake.
- A single-beat group (first beat has `in_last` = 1) is legal.

## Timing
- `in_ready`, `out_valid` and `busy` are pure decodes of the registered `state`. There is no combinational path from any input to any output.
- Latency from the last-beat handshake at edge k:
  - RESOLVE during cycle k+1.
  - With zero resolve iterations: `out_valid` high in cycle k+2.
  - Worst case: `out_valid` by cycle k+2+`ACC_WIDTH`.
- After the output handshake at edge m, `in_ready` is high in cycle m+1. There is no overlap between result hold and new accumulation.
- Throughput in ACCUM: one operand per cycle, independent of carry depth.
- `rst` asserted mid-group or mid-RESOLVE discards everything. No partial result is ever presented.
- `out_ready` high outside OUTPUT has no effect.

## Test plan
All scenarios use `WIDTH` = 8, `ACC_WIDTH` = 12.
1. Group of three operands: 0xFF, 0xFF, 0xFF (last). Required: `out_data` = 0x2FD, `out_valid` within 14 cycles of the last handshake.
2. Single beat 0x00 with last. Required: `out_valid` exactly 2 cycles after the handshake, `out_data` = 0x000.
3. Wrap and long carry chain: 16× 0xFF followed by 0x10 (last). Required: `out_data` = 0x000 (0x1000 mod 2^12). Check the iteration count is ≤ 12.
4. Backpressure: hold `out_ready` = 0 for 5 cycles in OUTPUT. Required: `out_valid` and `out_data` stable throughout, `in_ready` = 0. Then raise `out_ready`; `in_ready` = 1 on the next cycle and the next group starts from 0.
5. Input bubbles: toggle `in_valid` randomly across operands 0x12, 0x34, 0x56 (last). Required: `out_data` = 0x09C, no double-counting.
6. Reset mid-RESOLVE: assert `rst` one cycle after a last beat. Required: outputs go to 0 immediately. The next group, 0x05 (last), yields 0x005.
